// File: rtl/raster_scan_unit.sv
// Triangle scan-converter: walks the screen-clipped bounding box one position per
// cycle with incremental edge functions and emits covered pixels under backpressure.
module raster_scan_unit #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int COORD_W   = 12,
    parameter int ADDR_W    = 26,
    parameter int ATTR_W    = 24,
    parameter int CULL_BACK = 0,
    localparam int EDGE_W   = 2*COORD_W+2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COORD_W-1:0] x1,
    input  logic signed [COORD_W-1:0] y1,
    input  logic signed [COORD_W-1:0] x2,
    input  logic signed [COORD_W-1:0] y2,
    input  logic signed [COORD_W-1:0] x3,
    input  logic signed [COORD_W-1:0] y3,
    input  logic [ATTR_W-1:0]         attr_in,
    input  logic [ADDR_W-1:0]         addr_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [COORD_W-1:0] out_x,
    output logic signed [COORD_W-1:0] out_y,
    output logic [ADDR_W-1:0]         addr_out,
    output logic [ATTR_W-1:0]         attr_out,
    output logic signed [EDGE_W-1:0]  e0,
    output logic signed [EDGE_W-1:0]  e1,
    output logic signed [EDGE_W-1:0]  e2,
    output logic                      tri_done
);

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [EDGE_W-1:0]  edge_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETUP = 2'd1, S_SCAN = 2'd2} state_t;

    localparam coord_t X_LAST = coord_t'(SCREEN_W - 1);
    localparam coord_t Y_LAST = coord_t'(SCREEN_H - 1);

    // E_ab(px,py) evaluated at full edge precision.
    function automatic edge_t edge_at(input coord_t px, input coord_t py,
                                      input coord_t xa, input coord_t ya,
                                      input coord_t xb, input coord_t yb);
        return (edge_t'(px) - edge_t'(xa)) * (edge_t'(yb) - edge_t'(ya))
             - (edge_t'(py) - edge_t'(ya)) * (edge_t'(xb) - edge_t'(xa));
    endfunction

    function automatic edge_t cond_neg(input edge_t v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_t state, state_next;

    coord_t              vx [3];
    coord_t              vy [3];
    logic [ATTR_W-1:0]   lat_attr;
    logic [ADDR_W-1:0]   lat_base;

    coord_t              cur_x, cur_y, bx_min, bx_max, by_max;
    edge_t               ce [3];
    edge_t               re [3];
    edge_t               dx [3];
    edge_t               dy [3];
    logic [ADDR_W-1:0]   cur_addr, row_addr;

    coord_t              xmin, xmax, ymin, ymax;
    coord_t              bx_lo, bx_hi, by_lo, by_hi;
    logic                box_empty, area_neg, setup_skip;
    edge_t               area;
    edge_t               s_e  [3];
    edge_t               s_dx [3];
    edge_t               s_dy [3];
    logic [ADDR_W-1:0]   s_addr;

    logic                accept, scan_eval, last_pos, covered;

    assign accept   = in_valid && in_ready;
    assign last_pos = (cur_x == bx_max) && (cur_y == by_max);
    assign covered  = !ce[0][EDGE_W-1] && !ce[1][EDGE_W-1] && !ce[2][EDGE_W-1];

    // Setup: box, area, start edge values at the box origin and per-step increments.
    always_comb begin
        xmin = vx[0];
        xmax = vx[0];
        ymin = vy[0];
        ymax = vy[0];
        for (int unsigned k = 1; k < 3; k++) begin
            if (vx[k] < xmin) xmin = vx[k];
            if (vx[k] > xmax) xmax = vx[k];
            if (vy[k] < ymin) ymin = vy[k];
            if (vy[k] > ymax) ymax = vy[k];
        end
        // Only the side that can leave the screen is clamped, so a box lying fully
        // off-screen ends up with min > max rather than collapsing onto the border.
        bx_lo = xmin[COORD_W-1] ? '0 : xmin;
        by_lo = ymin[COORD_W-1] ? '0 : ymin;
        bx_hi = (xmax > X_LAST) ? X_LAST : xmax;
        by_hi = (ymax > Y_LAST) ? Y_LAST : ymax;
        box_empty = (bx_lo > bx_hi) || (by_lo > by_hi);

        area       = edge_at(vx[2], vy[2], vx[0], vy[0], vx[1], vy[1]);
        area_neg   = area[EDGE_W-1];
        setup_skip = (area == '0) || ((CULL_BACK != 0) && area_neg) || box_empty;

        for (int unsigned k = 0; k < 3; k++) begin
            s_e[k]  = cond_neg(edge_at(bx_lo, by_lo, vx[k], vy[k], vx[(k+1)%3], vy[(k+1)%3]),
                               area_neg);
            s_dx[k] = cond_neg(edge_t'(vy[(k+1)%3]) - edge_t'(vy[k]), area_neg);
            s_dy[k] = cond_neg(edge_t'(vx[k]) - edge_t'(vx[(k+1)%3]), area_neg);
        end
        s_addr = lat_base + ADDR_W'(by_lo) * ADDR_W'(SCREEN_W) + ADDR_W'(bx_lo);
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_SETUP;
            S_SETUP: state_next = setup_skip ? S_IDLE : S_SCAN;
            S_SCAN:  if (scan_eval && last_pos) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        scan_eval = 1'b0;
        case (state)
            S_IDLE:  in_ready  = reset;
            S_SCAN:  scan_eval = !out_valid || out_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tri_done  <= 1'b0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            addr_out  <= '0;
            attr_out  <= '0;
            e0        <= '0;
            e1        <= '0;
            e2        <= '0;
            lat_attr  <= '0;
            lat_base  <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            bx_min    <= '0;
            bx_max    <= '0;
            by_max    <= '0;
            cur_addr  <= '0;
            row_addr  <= '0;
            for (int unsigned k = 0; k < 3; k++) begin
                vx[k] <= '0;
                vy[k] <= '0;
                ce[k] <= '0;
                re[k] <= '0;
                dx[k] <= '0;
                dy[k] <= '0;
            end
        end else begin
            tri_done <= (state != S_IDLE) && (state_next == S_IDLE);

            if (accept) begin
                vx[0]    <= x1;
                vy[0]    <= y1;
                vx[1]    <= x2;
                vy[1]    <= y2;
                vx[2]    <= x3;
                vy[2]    <= y3;
                lat_attr <= attr_in;
                lat_base <= addr_in;
            end

            if (state == S_SETUP) begin
                cur_x    <= bx_lo;
                cur_y    <= by_lo;
                bx_min   <= bx_lo;
                bx_max   <= bx_hi;
                by_max   <= by_hi;
                cur_addr <= s_addr;
                row_addr <= s_addr;
                for (int unsigned k = 0; k < 3; k++) begin
                    ce[k] <= s_e[k];
                    re[k] <= s_e[k];
                    dx[k] <= s_dx[k];
                    dy[k] <= s_dy[k];
                end
            end else if (scan_eval && !last_pos) begin
                if (cur_x == bx_max) begin
                    cur_x    <= bx_min;
                    cur_y    <= cur_y + coord_t'(1);
                    row_addr <= row_addr + ADDR_W'(SCREEN_W);
                    cur_addr <= row_addr + ADDR_W'(SCREEN_W);
                    for (int unsigned k = 0; k < 3; k++) begin
                        re[k] <= re[k] + dy[k];
                        ce[k] <= re[k] + dy[k];
                    end
                end else begin
                    cur_x    <= cur_x + coord_t'(1);
                    cur_addr <= cur_addr + ADDR_W'(1);
                    for (int unsigned k = 0; k < 3; k++)
                        ce[k] <= ce[k] + dx[k];
                end
            end

            if (scan_eval && covered) begin
                out_valid <= 1'b1;
                out_x     <= cur_x;
                out_y     <= cur_y;
                addr_out  <= cur_addr;
                attr_out  <= lat_attr;
                e0        <= ce[0];
                e1        <= ce[1];
                e2        <= ce[2];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_raster_scan_unit.sv
// Directed bench for raster_scan_unit: coverage, winding/culling, clipping,
// degenerate input, backpressure, back-to-back triangles and mid-scan reset.
module tb_raster_scan_unit;

    localparam int CW = 12;
    localparam int AW = 26;
    localparam int TW = 24;
    localparam int EW = 2*CW+2;

    typedef struct packed {
        logic signed [CW-1:0] x;
        logic signed [CW-1:0] y;
        logic [AW-1:0]        addr;
        logic signed [EW-1:0] e0;
        logic signed [EW-1:0] e1;
        logic signed [EW-1:0] e2;
        logic [TW-1:0]        attr;
    } pix_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [CW-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0, x3 = '0, y3 = '0;
    logic [TW-1:0] attr_in = '0;
    logic [AW-1:0] addr_in = '0;

    logic                 in_ready, out_valid, tri_done;
    logic signed [CW-1:0] out_x, out_y;
    logic [AW-1:0]        addr_out;
    logic [TW-1:0]        attr_out;
    logic signed [EW-1:0] e0, e1, e2;

    logic                 c_in_ready, c_out_valid, c_tri_done;
    logic signed [CW-1:0] c_out_x, c_out_y;
    logic [AW-1:0]        c_addr_out;
    logic [TW-1:0]        c_attr_out;
    logic signed [EW-1:0] c_e0, c_e1, c_e2;

    raster_scan_unit #(.CULL_BACK(0)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
        .attr_in(attr_in), .addr_in(addr_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .addr_out(addr_out), .attr_out(attr_out),
        .e0(e0), .e1(e1), .e2(e2), .tri_done(tri_done)
    );

    raster_scan_unit #(.CULL_BACK(1)) dut_cull (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
        .attr_in(attr_in), .addr_in(addr_in), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_x(c_out_x), .out_y(c_out_y), .addr_out(c_addr_out), .attr_out(c_attr_out),
        .e0(c_e0), .e1(c_e1), .e2(c_e2), .tri_done(c_tri_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor state, cleared on request from the stimulus process.
    pix_t cap [$];
    pix_t exp_q [$];
    int   done_cnt, done_cyc, first_ov, stall_viol, stall_cnt, c_ov_cnt, c_done_cnt;
    bit   clr_req = 1'b0;
    bit   clr_seen = 1'b0;
    bit   prev_stall = 1'b0;
    pix_t prev_pix;

    always @(negedge clock) begin
        pix_t cur;
        cur = pix_t'{out_x, out_y, addr_out, e0, e1, e2, attr_out};
        if (clr_req != clr_seen) begin
            clr_seen   = clr_req;
            cap.delete();
            done_cnt   = 0;
            done_cyc   = -1;
            first_ov   = -1;
            stall_viol = 0;
            stall_cnt  = 0;
            c_ov_cnt   = 0;
            c_done_cnt = 0;
            prev_stall = 1'b0;
        end
        if (prev_stall && (!out_valid || cur != prev_pix)) stall_viol++;
        prev_stall = out_valid && !out_ready;
        prev_pix   = cur;
        if (out_valid && !out_ready) stall_cnt++;
        if (out_valid && out_ready) cap.push_back(cur);
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (tri_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (c_out_valid) c_ov_cnt++;
        if (c_tri_done) c_done_cnt++;
    end

    // Downstream: always ready, or 5-cycle hold after first valid then random.
    int bp_mode = 0;
    bit bp_seen = 1'b0;
    int bp_hold = 0;

    always @(posedge clock) begin
        #1;
        if (bp_mode == 0) begin
            bp_seen   = 1'b0;
            bp_hold   = 0;
            out_ready = 1'b1;
        end else begin
            if (!bp_seen && out_valid) bp_seen = 1'b1;
            if (bp_seen && bp_hold < 5) begin
                out_ready = 1'b0;
                bp_hold++;
            end else if (bp_seen) begin
                out_ready = ($urandom_range(0, 1) == 1);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic clear_mon();
        clr_req = ~clr_req;
        exp_q.delete();
    endtask

    function automatic pix_t mkpix(input int x, input int y, input int addr,
                                   input int a, input int b, input int c, input int at);
        pix_t p;
        p.x    = CW'(x);
        p.y    = CW'(y);
        p.addr = AW'(addr);
        p.e0   = EW'(a);
        p.e1   = EW'(b);
        p.e2   = EW'(c);
        p.attr = TW'(at);
        return p;
    endfunction

    // Right triangle with legs n on the axes: covered where x+y<=n.
    task automatic build_tri(input int n, input int base, input int at, input bit cw);
        for (int y = 0; y <= n; y++)
            for (int x = 0; x <= n; x++)
                if (x + y <= n)
                    exp_q.push_back(mkpix(x, y, base + y*640 + x,
                                          cw ? n*y : n*x, n*(n-x-y), cw ? n*x : n*y, at));
    endtask

    task automatic build_clip(input int at);
        for (int y = 478; y <= 479; y++)
            for (int x = 638; x <= 639; x++)
                exp_q.push_back(mkpix(x, y, y*640 + x, 7*(x-638), 7*(1123-x-y), 7*(y-478), at));
    endtask

    task automatic send(input int ax, input int ay, input int bx, input int by,
                        input int cx, input int cy, input int base, input int at,
                        input bit keep, output int t_acc);
        @(posedge clock); #1;
        x1 = CW'(ax); y1 = CW'(ay);
        x2 = CW'(bx); y2 = CW'(by);
        x3 = CW'(cx); y3 = CW'(cy);
        addr_in  = AW'(base);
        attr_in  = TW'(at);
        in_valid = 1'b1;
        t_acc = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (in_ready) begin
                t_acc = cyc;
                break;
            end
        end
        if (t_acc < 0) check("accept_timeout", 256'(in_ready), 256'(1));
        @(posedge clock); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 3000 && done_cnt < target; i++) @(negedge clock);
        check(tag, 256'(done_cnt), 256'(target));
        for (int i = 0; i < 300 && out_valid; i++) @(negedge clock);
        check({tag, "_drain"}, 256'(out_valid), 256'(0));
    endtask

    task automatic compare_pixels(input string tag);
        check({tag, "_count"}, 256'(cap.size()), 256'(exp_q.size()));
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            check($sformatf("%s_px%0d", tag, i), 256'(cap[i]), 256'(exp_q[i]));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int t, t2;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", 256'(in_ready), 256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_tri_done", 256'(tri_done), 256'(0));
        check("rst_data", 256'({out_x, out_y, addr_out, attr_out, e0, e1, e2}), 256'(0));
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        check("ready_after_rst", 256'(in_ready), 256'(1));

        // Clockwise winding: rasterised with negated edges, culled by the CULL_BACK=1 unit
        clear_mon();
        build_tri(4, 'h1000, 'h00FF00, 1'b1);
        send(0, 0, 4, 0, 0, 4, 'h1000, 'h00FF00, 1'b0, t);
        @(negedge clock);
        @(negedge clock);
        check("cull_done_t2", 256'(c_tri_done), 256'(1));
        check("cull_ready_t2", 256'(c_in_ready), 256'(1));
        wait_done(1, "cw_done");
        compare_pixels("cw");
        check("cull_no_valid", 256'(c_ov_cnt), 256'(0));
        check("cull_done_cnt", 256'(c_done_cnt), 256'(1));
        check("cull_data_idle",
              256'({c_out_x, c_out_y, c_addr_out, c_attr_out, c_e0, c_e1, c_e2}), 256'(0));

        // Counter-clockwise reference triangle
        clear_mon();
        build_tri(4, 'h1000, 'hABCDEF, 1'b0);
        send(0, 0, 0, 4, 4, 0, 'h1000, 'hABCDEF, 1'b0, t);
        wait_done(1, "ccw_done");
        compare_pixels("ccw");
        check("ccw_first_valid_cyc", 256'(first_ov), 256'(t + 3));
        check("ccw_done_cyc", 256'(done_cyc), 256'(t + 27));

        // Screen-edge clipping
        clear_mon();
        build_clip('h0C0C0C);
        send(638, 478, 638, 485, 645, 478, 0, 'h0C0C0C, 1'b0, t);
        wait_done(1, "clip_done");
        compare_pixels("clip");

        // Degenerate
        clear_mon();
        send(0, 0, 2, 2, 4, 4, 'h40, 'h444444, 1'b0, t);
        @(negedge clock);
        check("deg_ready_t1", 256'(in_ready), 256'(0));
        @(negedge clock);
        check("deg_ready_t2", 256'(in_ready), 256'(1));
        check("deg_done_t2", 256'(tri_done), 256'(1));
        repeat (5) @(negedge clock);
        check("deg_pixels", 256'(cap.size()), 256'(0));
        check("deg_done_cnt", 256'(done_cnt), 256'(1));

        // Backpressure
        clear_mon();
        build_tri(4, 'h1000, 'hABCDEF, 1'b0);
        bp_mode = 1;
        send(0, 0, 0, 4, 4, 0, 'h1000, 'hABCDEF, 1'b0, t);
        wait_done(1, "bp_done");
        bp_mode = 0;
        compare_pixels("bp");
        check("bp_stall_stable", 256'(stall_viol), 256'(0));
        check("bp_stalled", 256'(stall_cnt >= 5), 256'(1));

        // Back-to-back with in_valid held
        clear_mon();
        build_clip('h111111);
        build_tri(1, 0, 'h000055, 1'b0);
        send(638, 478, 638, 485, 645, 478, 0, 'h111111, 1'b1, t);
        send(0, 0, 0, 1, 1, 0, 0, 'h000055, 1'b0, t2);
        check("b2b_accept_cyc", 256'(t2), 256'(t + 6));
        wait_done(2, "b2b_done");
        compare_pixels("b2b");

        // Reset mid-scan, then a fresh triangle
        clear_mon();
        send(0, 0, 0, 4, 4, 0, 'h1000, 'h777777, 1'b0, t);
        for (int i = 0; i < 200 && cap.size() < 3; i++) @(negedge clock);
        check("mid_progress", 256'(cap.size() >= 3), 256'(1));
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("mid_rst_valid", 256'(out_valid), 256'(0));
        check("mid_rst_done", 256'(tri_done), 256'(0));
        check("mid_rst_ready", 256'(in_ready), 256'(0));
        check("mid_rst_data", 256'({out_x, out_y, addr_out, attr_out, e0, e1, e2}), 256'(0));
        @(posedge clock); #1 reset = 1'b1;
        clear_mon();
        repeat (40) @(negedge clock);
        check("post_rst_no_done", 256'(done_cnt), 256'(0));
        check("post_rst_no_px", 256'(cap.size()), 256'(0));
        clear_mon();
        build_tri(1, 'h2000, 'h0ABC0D, 1'b0);
        send(0, 0, 0, 1, 1, 0, 'h2000, 'h0ABC0D, 1'b0, t);
        wait_done(1, "fresh_done");
        compare_pixels("fresh");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/raster_scan_unit.md
# raster_scan_unit

Parametrised triangle scan-converter; successor to the fixed 640x480 rasterizer stage. Accepts one screen-space triangle per valid/ready handshake and walks its screen-clipped bounding box one position per cycle using incremental edge functions. It emits every covered pixel with framebuffer address, raw edge weights and a pass-through attribute word, under full output backpressure. It sits between vertex setup and the shading/depth stage; downstream normalises weights for interpolation.

## Interface
- SCREEN_W, 640: framebuffer width in pixels; row pitch for addressing.
- SCREEN_H, 480: framebuffer height in pixels.
- COORD_W, 12: signed integer pixel-coordinate width.
- ADDR_W, 26: framebuffer address width.
- ATTR_W, 24: per-triangle attribute width (flat colour etc.), passed through unchanged.
- CULL_BACK, 0: 1 = drop triangles with negative signed area; 0 = rasterise both windings.
- Derived: EDGE_W = 2*COORD_W+2.

- clock  in  1  sole clock, all logic on rising edge.
- reset  in  1  synchronous, active-low.
- in_valid  in  1  triangle offered.
- in_ready  out  1  block can accept a triangle.
- x1,y1,x2,y2,x3,y3  in  COORD_W each  signed vertex coordinates.
- attr_in  in  ATTR_W  triangle attribute.
- addr_in  in  ADDR_W  framebuffer base address.
- out_valid  out  1  pixel on output.
- out_ready  in  1  downstream accepts pixel.
- out_x, out_y  out  COORD_W each  pixel coordinates.
- addr_out  out  ADDR_W  addr_in + out_y*SCREEN_W + out_x.
- attr_out  out  ATTR_W  latched attr_in.
- e0, e1, e2  out  EDGE_W each  signed edge values E12, E23, E31 at pixel (winding-corrected, all >= 0).
- tri_done  out  1  one-cycle pulse when a triangle finishes (including culled/empty).

## Operation
- Edge function E_ab(x,y) = (x-xa)*(yb-ya) - (y-ya)*(xb-xa), full EDGE_W signed precision, no truncation.
- Signed area A = E_12(x3,y3). A == 0: degenerate, no pixels. A < 0 and CULL_BACK=1: culled, no pixels. A < 0 and CULL_BACK=0: all three edge values and increments negated.
- Pixel (x,y) covered iff e0>=0 && e1>=0 && e2>=0 (edges inclusive).
- Bounding box = vertex min/max, clamped to [0,SCREEN_W-1] x [0,SCREEN_H-1]; if clamped min > max on either axis, empty.
- Scan order row-major: x ascending within row, y ascending. Increments: x+1 adds (yb-ya); new row restores row-start value minus (xb-xa). Address likewise incremental (+1 per x, +SCREEN_W per row); no multiplier in scan loop.
- FSM:
  - IDLE: in_ready=1; on in_valid, latch vertices/attr/base -> SETUP.
  - SETUP (1 cycle): compute bbox, area, start edges, increments. Degenerate/culled/empty -> IDLE with tri_done pulse; else -> SCAN.
  - SCAN: evaluate current position when output register is free (!out_valid || out_ready); covered -> load output register; advance. After last bbox position evaluated -> IDLE with tri_done pulse.
- Reset values: in_ready=0 during reset cycle, then 1; out_valid=0, tri_done=0, all data outputs 0, FSM IDLE.

## Timing
- Accept at cycle T (in_valid && in_ready); in_ready=0 from T+1 until return to IDLE.
- SETUP at T+1; first position evaluated T+2; first covered pixel visible with out_valid at T+3 earliest.
- Throughput: one bbox position per cycle when unstalled.
- Stall: out_valid && !out_ready holds all output fields stable and freezes scan; no pixel dropped or duplicated.
- tri_done and in_ready=1 in the same cycle the FSM re-enters IDLE; final pixel may still be pending in output register (tri_done does not wait for it). Next triangle may be accepted that cycle.
- Culled/degenerate/empty: tri_done at T+2, zero pixels.
- Reset low mid-triangle: next cycle all state cleared, pending pixel discarded, no tri_done.

## Test plan
- CCW v=(0,0),(0,4),(4,0), addr_in=0x1000, attr=0xABCDEF -> exactly 15 pixels (x+y<=4), first (0,0) addr 0x1000 e=(0,16,0), last (0,4) addr 0x1A00, attr_out 0xABCDEF, one tri_done.
- Same vertices order (0,0),(4,0),(0,4): CULL_BACK=1 -> no out_valid, tri_done at T+2; CULL_BACK=0 -> same 15 pixels, all e >= 0.
- Clip: (638,478),(638,485),(645,478) -> exactly 4 pixels (638..639 x 478..479), none outside screen.
- Degenerate (0,0),(2,2),(4,4) -> zero pixels, tri_done at T+2, in_ready back at T+2.
- Backpressure: first triangle with out_ready low 5 cycles after first out_valid, then random 50% -> identical 15-pixel sequence, outputs stable while stalled.
- Back-to-back triangles with in_valid held high; reset pulsed mid-scan -> outputs zero next cycle, fresh triangle after reset rasterised correctly.
